score_writer: RTL
=================

SCORE_WRITER -- requirements
Module: score_writer

Interface
REQ-001 SHALL have port inclock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port sel, input, 2, song slot select, sampled only at record start.
REQ-004 SHALL have port rec_start, input, 1, single-cycle pulse that starts recording into the selected slot.
REQ-005 SHALL have port rec_stop, input, 1, single-cycle pulse that ends recording.
REQ-006 SHALL have port beat_tick, input, 1, single-cycle pulse marking one beat, which is one score entry.
REQ-007 SHALL have port key_valid, input, 1, high while a note key is held.
REQ-008 SHALL have port key_code, input, 5, note code of the held key.
REQ-009 SHALL have port wr_addr, output, 10, score RAM write address.
REQ-010 SHALL have port wr_data, output, 5, score RAM write data.
REQ-011 SHALL have port wr_en, output, 1, score RAM write strobe, one write per high cycle.
REQ-012 SHALL have port busy, output, 1, high while in REC or FILL.
REQ-013 SHALL have port full, output, 1, sticky flag: slot end reached during REC.
REQ-014 SHALL have port done, output, 1, one-cycle pulse on completion.
REQ-015 SHALL have port note_count, output, 9, number of entries written in REC for the current take.

Function
REQ-016 Slot address ranges SHALL be inclusive, with base/end as follows: sel=00 0/320; 01 328/456; 10 464/680; 11 688/808.
REQ-017 The FSM SHALL have states IDLE, REC, FILL, DONE.
REQ-018 In IDLE, rec_start SHALL latch sel, load ptr=base, clear full and note_count, and enter REC next cycle.
REQ-019 rec_start SHALL be ignored in REC/FILL; sel changes SHALL be ignored outside IDLE.
REQ-020 In REC, a beat_tick SHALL capture note = key_valid ? key_code : 5'd0 (rest).
REQ-021 Outputs SHALL be registered: wr_en=1, wr_addr=ptr, wr_data=note the cycle after the tick; ptr and note_count SHALL then increment.
REQ-022 If a tick writes ptr==end, the FSM SHALL set full=1 and go to DONE.
REQ-023 rec_stop in REC without a tick SHALL go to FILL with no write that cycle.
REQ-024 rec_stop and beat_tick in the same cycle SHALL write the tick's note first, then go to FILL starting at ptr+1.
REQ-025 If that write hits end, REQ-022 SHALL apply and FILL SHALL be skipped.
REQ-026 beat_tick and rec_stop SHALL be ignored outside REC.
REQ-027 In IDLE and DONE, wr_en SHALL be 0.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE; full SHALL hold until the next accepted rec_start.
REQ-029 note_count SHALL count REC writes only; FILL writes SHALL NOT be counted.

Reset
REQ-030 On rst_n=0 at any time, the FSM SHALL go to IDLE; ptr, wr_addr, wr_data, note_count SHALL be 0; wr_en, busy, full, done SHALL be 0.
REQ-031 A reset mid-REC/FILL SHALL abort without further writes; partial slot contents are left as written.
REQ-032 The first rec_start SHALL be honoured on the first clock edge after rst_n deasserts.

Configuration
REQ-033 Macro SCORE_FILL_EN SHALL control FILL behaviour.
REQ-034 With SCORE_FILL_EN defined, FILL SHALL write 5'd0 to every remaining address through end, one per clock (wr_en=1 each cycle), then go to DONE.
REQ-035 Without SCORE_FILL_EN, FILL SHALL not exist: rec_stop SHALL go directly to DONE with no padding writes.

Verification
REQ-036 Bench SHALL check: sel=01, rec_start, 3 ticks with key_code=7/9/0-invalid -> writes (328,7),(329,9),(330,0); note_count=3.
REQ-037 Bench SHALL check: sel=11, 121 ticks -> last write at 808; full=1; done pulse; wr_en low afterward; full persists until next rec_start.
REQ-038 Bench SHALL check with SCORE_FILL_EN: sel=10, 2 ticks, rec_stop -> writes 464,465 with notes, then 466..680 = 0 on 215 consecutive cycles, then done.
REQ-039 Bench SHALL check without SCORE_FILL_EN: same stimulus -> only 2 writes, done one cycle after rec_stop.
REQ-040 Bench SHALL check: rec_stop+beat_tick same cycle at ptr=320, sel=00 -> write 320; full=1; no FILL.
REQ-041 Bench SHALL check: rst_n low during FILL at address 500 -> wr_en drops immediately; all outputs 0; rec_start with sel change during REC ignored.

Source files
------------

// File: rtl/score_writer.sv
// -----------------------------------------------------------------------------
// score_writer
//
// Records a live keyboard performance into one of four fixed song slots of an
// external score RAM. Each beat_tick produces one score entry: the held note,
// or 5'd0 (rest) when no key is held. A take ends either when the slot end is
// written (full) or on rec_stop. In the optional padding build the rest of the
// slot is then cleared to rests, one address per clock.
//
// Configuration macro:
//   SCORE_FILL_EN  defined   -> rec_stop enters FILL, which writes 5'd0 to every
//                               remaining slot address through the slot end.
//                  undefined -> no FILL state; rec_stop finishes the take at once.
//
// Ports:
//   inclock     in   1   sole clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   sel         in   2   song slot select, sampled only when a take starts
//   rec_start   in   1   pulse: start a take into the selected slot (IDLE only)
//   rec_stop    in   1   pulse: end the take (REC only)
//   beat_tick   in   1   pulse: one beat = one score entry (REC only)
//   key_valid   in   1   a note key is held
//   key_code    in   5   note code of the held key
//   wr_addr     out  10  score RAM write address
//   wr_data     out  5   score RAM write data
//   wr_en       out  1   score RAM write strobe, one write per high cycle
//   busy        out  1   high while recording or padding
//   full        out  1   sticky: slot end reached while recording
//   done        out  1   one-cycle pulse when the take completes
//   note_count  out  9   entries written while recording in the current take
// -----------------------------------------------------------------------------
module score_writer (
    input  logic       inclock,
    input  logic       rst_n,
    input  logic [1:0] sel,
    input  logic       rec_start,
    input  logic       rec_stop,
    input  logic       beat_tick,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic [9:0] wr_addr,
    output logic [4:0] wr_data,
    output logic       wr_en,
    output logic       busy,
    output logic       full,
    output logic       done,
    output logic [8:0] note_count
);

`ifdef SCORE_FILL_EN
    typedef enum logic [1:0] {S_IDLE, S_REC, S_FILL, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REC, S_DONE} state_t;
`endif

    state_t     r_state;
    logic [9:0] r_ptr;        // next address to be written
    logic [9:0] r_end;        // inclusive last address of the latched slot

    logic [9:0] w_slot_base;
    logic [9:0] w_slot_end;
    logic [4:0] w_note;
    logic       w_at_end;

    // Slot map; the small gaps between slots are never written.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_slot_base = 10'd0;
        w_slot_end  = 10'd320;
        unique case (sel)
            2'b00: begin w_slot_base = 10'd0;   w_slot_end = 10'd320; end
            2'b01: begin w_slot_base = 10'd328; w_slot_end = 10'd456; end
            2'b10: begin w_slot_base = 10'd464; w_slot_end = 10'd680; end
            2'b11: begin w_slot_base = 10'd688; w_slot_end = 10'd808; end
        endcase
    end

    assign w_note   = key_valid ? key_code : 5'd0;   // no key held -> rest
    assign w_at_end = (r_ptr == r_end);

    // Single state machine with registered outputs. busy and done are set on
    // the same edge that changes state, so they track the state exactly. A
    // write is presented the cycle after the edge that decided it, so the last
    // write of a take shares its cycle with the done pulse.
    always_ff @(posedge inclock or negedge rst_n) begin
        // NOTE: every register here is a plain flop with an async reset; non-blocking
        // assignments keep all updates on one edge independent of statement order.
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 10'd0;
            r_end      <= 10'd0;
            wr_addr    <= 10'd0;
            wr_data    <= 5'd0;
            wr_en      <= 1'b0;
            busy       <= 1'b0;
            full       <= 1'b0;
            done       <= 1'b0;
            note_count <= 9'd0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (rec_start) begin
                        r_state    <= S_REC;
                        r_ptr      <= w_slot_base;
                        r_end      <= w_slot_end;
                        full       <= 1'b0;
                        note_count <= 9'd0;
                        busy       <= 1'b1;
                    end
                end

                S_REC: begin
                    if (beat_tick) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= r_ptr;
                        wr_data    <= w_note;
                        r_ptr      <= r_ptr + 10'd1;
                        note_count <= note_count + 9'd1;
                    end

                    // Reaching the slot end wins over a simultaneous rec_stop,
                    // so a full slot never enters padding.
                    if (beat_tick && w_at_end) begin
                        full    <= 1'b1;
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (rec_stop) begin
`ifdef SCORE_FILL_EN
                        // Padding resumes at r_ptr, which already accounts
                        // for a tick taken in this same cycle.
                        r_state <= S_FILL;
`else
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
`endif
                    end
                end

`ifdef SCORE_FILL_EN
                S_FILL: begin
                    wr_en   <= 1'b1;
                    wr_addr <= r_ptr;
                    wr_data <= 5'd0;
                    r_ptr   <= r_ptr + 10'd1;
                    if (w_at_end) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
`endif

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
